// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file and its write-pending scoreboard.
// Register 0 is hardwired to zero and is never tracked as pending.
package regfile_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits, their population count and the combinational read-hazard stall.
// Pending updates land on the edge after issue/write; Stall is 0-cycle; no backpressure, consumer must hold on Stall.
module reg_scoreboard #(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic                  IssueEn,
  input  logic [ADDR_WIDTH-1:0] IssueReg,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic                  Stall,
  output logic [ADDR_WIDTH:0]   PendingCnt
);
  import regfile_pkg::*;

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic             wr_vld;
  logic             iss_vld;
  logic             set_new;
  logic             clr_eff;
  logic             haz1;
  logic             haz2;

  assign wr_vld  = RegWrite && (WriteReg != ZERO_REG);
  assign iss_vld = IssueEn && (IssueReg != ZERO_REG);

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wr_vld)  clr_mask[WriteReg] = 1'b1;
    if (iss_vld) set_mask[IssueReg] = 1'b1;
  end

  // Count tracks transitions only: a re-issue to the register being written keeps it pending.
  assign set_new = iss_vld && !pending[IssueReg];
  assign clr_eff = wr_vld && pending[WriteReg] && !(iss_vld && (IssueReg == WriteReg));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending    <= '0;
      PendingCnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (set_new && !clr_eff)
        PendingCnt <= PendingCnt + CNT_ONE;
      else if (clr_eff && !set_new)
        PendingCnt <= PendingCnt - CNT_ONE;
    end
  end

  assign haz1  = pending[ReadReg1] && !(RegWrite && (WriteReg == ReadReg1)) && (ReadReg1 != ZERO_REG);
  assign haz2  = pending[ReadReg2] && !(RegWrite && (WriteReg == ReadReg2)) && (ReadReg2 != ZERO_REG);
  assign Stall = !Reset && (haz1 || haz2);
endmodule

// File: rtl/reg_file_sb.sv
// 32-entry register file, two combinational read ports with write-through bypass, r0 hardwired to 0.
// Read latency 0, write visible in storage from next edge; no backpressure, consumer holds while Stall is high.
module reg_file_sb #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  IssueEn,
  input  logic [ADDR_WIDTH-1:0] IssueReg,
  output logic                  Stall,
  output logic [ADDR_WIDTH:0]   PendingCnt
);
  import regfile_pkg::*;

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (RegWrite && (WriteReg != ZERO_REG)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Reads are forced to zero during reset so a same-cycle bypass cannot leak through.
  always_comb begin
    ReadData1 = regs[ReadReg1];
    if (Reset || (ReadReg1 == ZERO_REG))
      ReadData1 = '0;
    else if (RegWrite && (WriteReg == ReadReg1))
      ReadData1 = WriteData;
  end

  always_comb begin
    ReadData2 = regs[ReadReg2];
    if (Reset || (ReadReg2 == ZERO_REG))
      ReadData2 = '0;
    else if (RegWrite && (WriteReg == ReadReg2))
      ReadData2 = WriteData;
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .Clk        (Clk),
    .Reset      (Reset),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .IssueEn    (IssueEn),
    .IssueReg   (IssueReg),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .Stall      (Stall),
    .PendingCnt (PendingCnt)
  );
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Register file with an integrated write-pending scoreboard. It sits directly downstream of the 5-bit write-register select mux: that mux's output (rt/rd choice) drives `WriteReg`, and this block commits `WriteData` to the selected register. It provides two combinational read ports with write-through bypass, a hardwired-zero register 0, and per-register pending bits so the control unit can stall a consumer until its producer writes back.

## Interface
- `DATA_WIDTH`, 32, register and data width.
- `ADDR_WIDTH`, 5, register address width; register count is 2^ADDR_WIDTH = 32.

Ports:
- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all registers, pending bits and `PendingCnt`.
- `ReadReg1`, `ReadReg2`  in  ADDR_WIDTH  read addresses.
- `ReadData1`, `ReadData2`  out  DATA_WIDTH  combinational read data.
- `RegWrite`  in  1  write enable.
- `WriteReg`  in  ADDR_WIDTH  write address, driven by the write-register select mux.
- `WriteData`  in  DATA_WIDTH  write-back data.
- `IssueEn`  in  1  an instruction that will write `IssueReg` is issued this cycle.
- `IssueReg`  in  ADDR_WIDTH  destination of the issuing instruction.
- `Stall`  out  1  a read address targets a pending register not being written this cycle.
- `PendingCnt`  out  ADDR_WIDTH+1  number of pending registers (0..31).

## Operation
- **Storage:** 32 x DATA_WIDTH flops. Register 0 always reads 0. Writes to register 0 are dropped. Register 0 is never pending.
- **Write:** on the rising edge, if `RegWrite` and `WriteReg != 0`, then `regs[WriteReg] <= WriteData`.
- **Read:** `ReadDataN` is combinational.
  - 0 if `ReadRegN == 0`.
  - Otherwise `WriteData` if `RegWrite && WriteReg == ReadRegN` (bypass).
  - Otherwise `regs[ReadRegN]`.
- **Scoreboard:** `pending[31:0]`. Per edge, evaluated in this order:
  1. Clear `pending[WriteReg]` if `RegWrite && WriteReg != 0`.
  2. Set `pending[IssueReg]` if `IssueEn && IssueReg != 0`.
  - Set wins when both address the same register; that register stays pending for the new producer.
- **Stall:** `Stall = hazN(1) | hazN(2)`, where `hazN = pending[ReadRegN] && !(RegWrite && WriteReg == ReadRegN) && ReadRegN != 0`. This is combinational.
- **PendingCnt:** a registered counter, always equal to popcount(pending). Per-edge delta is -1, 0 or +1:
  - +1 for a set of a non-pending register.
  - -1 for a clear of a pending register that is not also re-set that cycle.
  - 0 for all other cases, including issue to an already-pending register, write to a non-pending register, and set+clear of the same pending register.
  - Clear of register A together with set of a different, non-pending register B gives a net 0.
  - Must never wrap. 31 is the maximum, reached with every nonzero register pending.

## Timing
- Read latency is 0 cycles (combinational). A write is visible in `regs` from the edge after `RegWrite`; the bypass makes it visible in the same cycle.
- The pending bit is set from the edge after `IssueEn`. `Stall` for that register asserts in the following cycle.
- Reset values: all registers 0, pending all 0, `PendingCnt` 0. `ReadData1`/`ReadData2` are therefore 0 and `Stall` is 0 while `Reset` is high.
- Reset asserted mid-operation takes effect immediately (asynchronous), discarding any same-cycle write or issue. Deassertion is synchronous to the next `Clk` edge.
- No handshake back-pressure. The control unit must hold the consumer while `Stall` = 1.

## Structure
- **Shared package `regfile_pkg`:** `DATA_WIDTH`, `ADDR_WIDTH`, `NUM_REGS`, `ZERO_REG = 0`.
- **Sub-module `reg_scoreboard`:** holds `pending`, `PendingCnt` and the `Stall` logic. Inputs: write/issue strobes, addresses, read addresses.
- **Top level:** contains storage, the write path and the read/bypass muxes.

## Test plan
- **Reset then write/read:** Reset, then write 0xDEADBEEF to r5. `ReadReg1=5` returns 0xDEADBEEF in the same cycle (bypass) and on the next cycle (stored); `Stall=0`.
- **Register 0:** write 0x12345678 to r0. `ReadData1` for r0 is 0; `IssueEn` to r0 leaves `PendingCnt=0`.
- **Issue/stall/write-back:** issue r8, then read r8 with no write: `Stall=1`, `PendingCnt=1`. Write r8=0xA5 with `ReadReg2=8` in the same cycle: `Stall=0`, `ReadData2=0xA5`; next cycle `PendingCnt=0`.
- **Simultaneous events:**
  - Issue r3 and write r3 in the same cycle (r3 already pending): r3 stays pending, `PendingCnt` unchanged.
  - Issue r4 while writing pending r9: count unchanged, r4 pending, r9 clear.
- **Full and async reset:** issue r1..r31 on consecutive cycles: `PendingCnt=31`. Assert `Reset` mid-cycle: `PendingCnt=0`, `Stall=0`, all reads 0 without waiting for a clock edge.
